stim_seq_ctrl: RTL and testbench



---
 rtl/stim_seq_ctrl_if.sv | 44 ++++
 rtl/stim_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_stim_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_seq_ctrl_if.sv
// Handshake bundle between a stimulus consumer and the stim_seq_ctrl sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; pause is the only throttle and it is level-sensitive.
//
// Signals:
//   start     - begin a sequence (sampled by the sequencer only while idle)
//   pause     - freeze the pattern hold counter while patterns are driven
//   dut_rst_n - active-low reset toward the device under test
//   pattern   - current stimulus value (WIDTH bits)
//   pat_valid - pattern is being driven
//   busy      - a sequence is in progress
//   done      - one-cycle completion pulse
// master: the side that requests sequences; slave: the sequencer itself.
interface stim_seq_ctrl_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic             pause;
    logic             dut_rst_n;
    logic [WIDTH-1:0] pattern;
    logic             pat_valid;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output pause,
        input  dut_rst_n,
        input  pattern,
        input  pat_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  pause,
        output dut_rst_n,
        output pattern,
        output pat_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/stim_seq_ctrl.sv
// Stimulus sequencer: DUT reset pulse, then walk pattern 0..LAST, then a done pulse.
// Latency: done is high RST_CYCLES + (LAST+1)*STEP_CYCLES cycles after start is sampled.
// Backpressure: pause freezes the pattern walk in DRIVE; start is ignored while busy.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - asynchronous active-high reset, returns everything to idle
//   bus (slave)    - start/pause in; dut_rst_n, pattern, pat_valid, busy, done out
// All outputs are registered; start and pause never reach an output combinationally.
//
// Optional build macro STIM_SEQ_CTRL_LOOP_EN: after each pass the sequencer
// restarts the pattern walk directly (no DUT reset), pulsing done once per
// pass and staying busy until rst. Without it, one pass runs per start.
module stim_seq_ctrl #(
    parameter int WIDTH       = 2,
    parameter int STEP_CYCLES = 10,
    parameter int RST_CYCLES  = 2,
    parameter int LAST        = (1 << WIDTH) - 1
) (
    input  logic            clk,
    input  logic            rst,
    stim_seq_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (STEP_CYCLES > RST_CYCLES) ? STEP_CYCLES : RST_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_END  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_END = CNT_W'(STEP_CYCLES - 1);
    localparam logic [WIDTH-1:0] PAT_LAST = WIDTH'(LAST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             dut_rst_n;
    logic [WIDTH-1:0] pattern;
    logic             pat_valid;
    logic             busy;
    logic             done;

    // Outputs are updated in the same edge as the state transition that
    // implies them, so each output is a flop rather than a decode of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            dut_rst_n <= 1'b1;
            pattern   <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_RESET;
                        hold_cnt  <= '0;
                        dut_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        // Pattern has been holding LAST since the last pass.
                        pattern   <= '0;
                    end
                end

                S_RESET: begin
                    if (hold_cnt == RST_END) begin
                        state     <= S_DRIVE;
                        hold_cnt  <= '0;
                        dut_rst_n <= 1'b1;
                        pat_valid <= 1'b1;
                        pattern   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                S_DRIVE: begin
                    if (!bus.pause) begin
                        if (hold_cnt == STEP_END) begin
                            hold_cnt <= '0;
                            if (pattern == PAT_LAST) begin
                                state     <= S_DONE;
                                pat_valid <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                // Cannot wrap: LAST never exceeds the all-ones value.
                                pattern <= pattern + WIDTH'(1);
                            end
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end

                S_DONE: begin
`ifdef STIM_SEQ_CTRL_LOOP_EN
                    state     <= S_DRIVE;
                    hold_cnt  <= '0;
                    pattern   <= '0;
                    pat_valid <= 1'b1;
`else
                    state <= S_IDLE;
                    busy  <= 1'b0;
`endif
                end

                default: begin
                    state     <= S_IDLE;
                    hold_cnt  <= '0;
                    dut_rst_n <= 1'b1;
                    pattern   <= '0;
                    pat_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_rst_n = dut_rst_n;
    assign bus.pattern   = pattern;
    assign bus.pat_valid = pat_valid;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// Directed bench for stim_seq_ctrl: default and small-parameter instances.
// Cycle k is the period starting at the k-th rising edge after start is sampled.
module tb_stim_seq_ctrl;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    stim_seq_ctrl_if #(.WIDTH(2)) if1 ();
    stim_seq_ctrl_if #(.WIDTH(3)) if2 ();

    stim_seq_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    stim_seq_ctrl #(
        .WIDTH       (3),
        .STEP_CYCLES (1),
        .RST_CYCLES  (1),
        .LAST        (5)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {dut_rst_n, pat_valid, busy, done, pattern}
    logic [5:0] smp1 [0:199];
    logic [6:0] smp2 [0:199];

    // Samples both instances mid-cycle for n cycles; start is presented so that
    // the first rising edge inside this task is edge E0.
    task automatic capture(input int n, input int p_from, input int p_to,
                           input int s_a, input int s_b, input bit go1, input bit go2);
        @(negedge clk);
        if1.start = go1;
        if2.start = go2;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            smp1[k] = {if1.dut_rst_n, if1.pat_valid, if1.busy, if1.done, if1.pattern};
            smp2[k] = {if2.dut_rst_n, if2.pat_valid, if2.busy, if2.done, if2.pattern};
            if1.start = (k == s_a) || (k == s_b);
            if2.start = 1'b0;
            if1.pause = (k >= p_from) && (k <= p_to);
        end
        if1.start = 1'b0;
        if1.pause = 1'b0;
    endtask

    // Expected default-parameter timeline; extra = cycles paused while pattern==1.
    function automatic logic [5:0] exp_default(input int k, input int extra);
        int t2, t3, td;
        logic [1:0] p;
        t2 = 22 + extra;
        t3 = 32 + extra;
        td = 42 + extra;
        if (k < 12)      p = 2'd0;
        else if (k < t2) p = 2'd1;
        else if (k < t3) p = 2'd2;
        else             p = 2'd3;
        return {(k >= 2), (k >= 2 && k < td), (k <= td), (k == td), p};
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({if1.dut_rst_n, if1.pat_valid, if1.busy, if1.done, if1.pattern} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_idle_dflt got=%b exp=%b",
                     {if1.dut_rst_n, if1.pat_valid, if1.busy, if1.done, if1.pattern}, 6'b100000);
        end
        checks++;
        if ({if2.dut_rst_n, if2.pat_valid, if2.busy, if2.done, if2.pattern} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_idle_small got=%b exp=%b",
                     {if2.dut_rst_n, if2.pat_valid, if2.busy, if2.done, if2.pattern}, 7'b1000000);
        end
        // start presented together with rst: rst wins.
        @(negedge clk);
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({if1.dut_rst_n, if1.busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_beats_start got=%b exp=%b", {if1.dut_rst_n, if1.busy}, 2'b10);
        end
        @(negedge clk);
        if1.start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        capture(50, -1, -1, -1, -1, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (smp1[k] !== exp_default(k, 0)) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", k, smp1[k], exp_default(k, 0));
            end
        end
    endtask

    task automatic test_pause();
        // pause high during cycles 14..18: five frozen edges while pattern==1
        capture(55, 14, 18, -1, -1, 1'b1, 1'b0);
        for (int k = 0; k < 55; k++) begin
            checks++;
            if (smp1[k] !== exp_default(k, 5)) begin
                errors++;
                $display("FAIL pause cyc=%0d got=%b exp=%b", k, smp1[k], exp_default(k, 5));
            end
        end
    endtask

    task automatic test_restart_ignored();
        int n_done;
        n_done = 0;
        capture(60, -1, -1, 5, 30, 1'b1, 1'b0);
        for (int k = 0; k < 60; k++) begin
            if (smp1[k][2]) n_done++;
            checks++;
            if (smp1[k] !== exp_default(k, 0)) begin
                errors++;
                $display("FAIL restart cyc=%0d got=%b exp=%b", k, smp1[k], exp_default(k, 0));
            end
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL restart_done_count got=%0d exp=%0d", n_done, 1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (if1.pattern !== 2'd2) begin
            errors++;
            $display("FAIL arst_pre_pattern got=%0d exp=%0d", if1.pattern, 2);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if1.dut_rst_n, if1.pat_valid, if1.busy, if1.done, if1.pattern} !== 6'b100000) begin
            errors++;
            $display("FAIL arst_immediate got=%b exp=%b",
                     {if1.dut_rst_n, if1.pat_valid, if1.busy, if1.done, if1.pattern}, 6'b100000);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({if1.dut_rst_n, if1.busy, if1.pattern} !== 4'b1000) begin
            errors++;
            $display("FAIL arst_held got=%b exp=%b", {if1.dut_rst_n, if1.busy, if1.pattern}, 4'b1000);
        end
        @(negedge clk);
        rst = 1'b0;
        capture(50, -1, -1, -1, -1, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (smp1[k] !== exp_default(k, 0)) begin
                errors++;
                $display("FAIL arst_replay cyc=%0d got=%b exp=%b", k, smp1[k], exp_default(k, 0));
            end
        end
    endtask

    task automatic test_small_params();
        logic [6:0] e;
        capture(12, -1, -1, -1, -1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            // reset cycle 0, patterns 0..5 in cycles 1..6, done in cycle 7
            e = {(k >= 1), (k >= 1 && k <= 6), (k <= 7), (k == 7),
                 (k < 1) ? 3'd0 : (k <= 6) ? 3'(k - 1) : 3'd5};
            checks++;
            if (smp2[k] !== e) begin
                errors++;
                $display("FAIL small cyc=%0d got=%b exp=%b", k, smp2[k], e);
            end
        end
    endtask

    // Each pass in loop mode is (LAST+1)*STEP_CYCLES drive cycles plus the DONE cycle.
    task automatic test_loop();
        logic [2:0] e;
        capture(140, -1, -1, 60, -1, 1'b1, 1'b0);
        for (int k = 0; k < 140; k++) begin
            e = {(k >= 2), 1'b1, (k == 42 || k == 83 || k == 124)};
            checks++;
            if ({smp1[k][5], smp1[k][3], smp1[k][2]} !== e) begin
                errors++;
                $display("FAIL loop cyc=%0d got=%b exp=%b", k,
                         {smp1[k][5], smp1[k][3], smp1[k][2]}, e);
            end
        end
        checks++;
        if (smp1[42][1:0] !== 2'd3) begin
            errors++;
            $display("FAIL loop_pat42 got=%0d exp=%0d", smp1[42][1:0], 3);
        end
        checks++;
        if (smp1[43][1:0] !== 2'd0) begin
            errors++;
            $display("FAIL loop_pat43 got=%0d exp=%0d", smp1[43][1:0], 0);
        end
        checks++;
        if (smp1[84][1:0] !== 2'd0) begin
            errors++;
            $display("FAIL loop_pat84 got=%0d exp=%0d", smp1[84][1:0], 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        if1.start = 1'b0;
        if1.pause = 1'b0;
        if2.start = 1'b0;
        if2.pause = 1'b0;
        test_reset();
`ifdef STIM_SEQ_CTRL_LOOP_EN
        test_loop();
`else
        test_basic();
        test_pause();
        test_restart_ignored();
        test_async_reset();
        test_small_params();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
